// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the sum-of-products sequencer.
// FSM encodings are plain localparams so older tools and the legacy include stay compatible.
package mac_seq_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int MUL_W  = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MUL_AB = 3'd1;
    localparam logic [2:0] ST_MUL_CD = 3'd2;
    localparam logic [2:0] ST_MUL_P  = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    // Byte lanes of one input word, MSB first: a=[31:24] .. d=[7:0].
    typedef struct packed {
        logic [BYTE_W-1:0] a;
        logic [BYTE_W-1:0] b;
        logic [BYTE_W-1:0] c;
        logic [BYTE_W-1:0] d;
    } operands_t;

    function automatic logic [MUL_W-1:0] zext_byte(input logic [BYTE_W-1:0] v);
        return {{(MUL_W-BYTE_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Word stream in, result out, plus the busy flag; slave is the sequencer's view.
interface mac_seq_ctrl_if
    import mac_seq_ctrl_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;
    logic [ACC_W-1:0]  m_data;
    logic [CNT_W-1:0]  m_count;
    logic              m_valid;
    logic              m_ready;
    logic              busy;

    modport slave (
        input  s_data, s_last, s_valid, m_ready,
        output s_ready, m_data, m_count, m_valid, busy
    );

    modport master (
        output s_data, s_last, s_valid, m_ready,
        input  s_ready, m_data, m_count, m_valid, busy
    );
endinterface

// File: rtl/mac_seq_ctrl_mul16.sv
// Shared 16x16 -> 32 unsigned multiplier.
// Latency: combinational.
// Backpressure: none; operands come from the owning FSM's mux.
module mac_seq_ctrl_mul16
    import mac_seq_ctrl_pkg::*;
(
    input  logic [MUL_W-1:0]   op_a,
    input  logic [MUL_W-1:0]   op_b,
    output logic [2*MUL_W-1:0] prod
);
    assign prod = {{MUL_W{1'b0}}, op_a} * {{MUL_W{1'b0}}, op_b};
endmodule

// File: rtl/mac_seq_ctrl.sv
// Sums (a*b)*(c*d) over an s_last-delimited vector using one shared multiplier.
// Latency: last-word accept to m_valid = 4 cycles; one word per 4 cycles.
// Backpressure: s_ready only in IDLE; result held in OUT until m_ready.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.slave  bus
);

    logic [2:0]         state_q,   state_d;
    operands_t          word_q,    word_d;
    logic               last_q,    last_d;
    logic [MUL_W-1:0]   p0_q,      p0_d;
    logic [MUL_W-1:0]   p1_q,      p1_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               m_valid_q, m_valid_d;
    logic [ACC_W-1:0]   m_data_q,  m_data_d;
    logic [CNT_W-1:0]   m_count_q, m_count_d;

    logic [MUL_W-1:0]   op_a;
    logic [MUL_W-1:0]   op_b;
    logic [2*MUL_W-1:0] prod;
    logic               s_ready_int;
    logic               accept;

    assign s_ready_int = (state_q == ST_IDLE) & ~rst;
    assign accept      = bus.s_valid & s_ready_int;

    // Operand mux: the state alone decides what the single multiplier sees.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            ST_MUL_AB: begin
                op_a = zext_byte(word_q.a);
                op_b = zext_byte(word_q.b);
            end
            ST_MUL_CD: begin
                op_a = zext_byte(word_q.c);
                op_b = zext_byte(word_q.d);
            end
            ST_MUL_P: begin
                op_a = p0_q;
                op_b = p1_q;
            end
            default: ;
        endcase
    end

    mac_seq_ctrl_mul16 u_mul (
        .op_a (op_a),
        .op_b (op_b),
        .prod (prod)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        last_d    = last_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_count_d = m_count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = operands_t'(bus.s_data);
                    last_d  = bus.s_last;
                    state_d = ST_MUL_AB;
                end
            end
            ST_MUL_AB: begin
                p0_d    = prod[MUL_W-1:0];
                state_d = ST_MUL_CD;
            end
            ST_MUL_CD: begin
                p1_d    = prod[MUL_W-1:0];
                state_d = ST_MUL_P;
            end
            ST_MUL_P: begin
                acc_d = acc_q + ACC_W'(prod);
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (last_q) begin
                    // Result registers load from the updated sums so OUT presents them at once.
                    m_valid_d = 1'b1;
                    m_data_d  = acc_d;
                    m_count_d = cnt_d;
                    state_d   = ST_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    m_valid_d = 1'b0;
                    m_data_d  = '0;
                    m_count_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            last_q    <= 1'b0;
            p0_q      <= '0;
            p1_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_count_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            last_q    <= last_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_count_q <= m_count_d;
        end
    end

    assign bus.s_ready = s_ready_int;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_count = m_count_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule
